lane_deserializer8: RTL and testbench

Collects a stream of WIDTH-bit words arriving one per accepted handshake and presents them as eight parallel lanes a..h, together with a lane count. It sits upstream of the eight-operand reduction units, which consume eight WIDTH-bit operands at once. It turns a single narrow producer into the eight-port operand bundle those units expect. Partial bundles are supported via in_last; unfilled lanes read as zero.

---
 rtl/lane_deserializer8_if.sv | 23 ++
 rtl/lane_deserializer8.sv | 65 ++++++
 tb/tb_lane_deserializer8.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/lane_deserializer8_if.sv
// Handshake and lane bundle between a narrow word producer and eight-operand consumers.
interface lane_deserializer8_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] a, b, c, d, e, f, g, h;
    logic [3:0]       out_count;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, a, b, c, d, e, f, g, h, out_count
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, a, b, c, d, e, f, g, h, out_count
    );
endinterface

// File: rtl/lane_deserializer8.sv
// Gathers up to eight words into parallel lanes a..h, closing a bundle on the
// eighth word or on in_last, then holds it until the consumer takes it.
module lane_deserializer8 #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 areset,
    lane_deserializer8_if.slave  bus
);
    typedef enum logic {FILL, HOLD} state_t;

    state_t           state_reg;
    logic [2:0]       idx_reg;
    logic [3:0]       count_reg;
    logic             valid_reg;
    logic [WIDTH-1:0] lane_reg [8];

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state_reg <= FILL;
            idx_reg   <= 3'd0;
            count_reg <= 4'd0;
            valid_reg <= 1'b0;
            for (int i = 0; i < 8; i++) lane_reg[i] <= '0;
        end else begin
            case (state_reg)
                FILL: begin
                    if (bus.in_valid) begin
                        lane_reg[idx_reg] <= bus.in_data;
                        if (idx_reg == 3'd7 || bus.in_last) begin
                            count_reg <= {1'b0, idx_reg} + 4'd1;
                            idx_reg   <= 3'd0;
                            valid_reg <= 1'b1;
                            state_reg <= HOLD;
                        end else begin
                            idx_reg <= idx_reg + 3'd1;
                        end
                    end
                end
                HOLD: begin
                    // Clearing on delivery keeps unfilled lanes of the next bundle at zero.
                    if (bus.out_ready) begin
                        for (int i = 0; i < 8; i++) lane_reg[i] <= '0;
                        count_reg <= 4'd0;
                        valid_reg <= 1'b0;
                        state_reg <= FILL;
                    end
                end
                default: state_reg <= FILL;
            endcase
        end
    end

    assign bus.in_ready  = (state_reg == FILL);
    assign bus.out_valid = valid_reg;
    assign bus.out_count = count_reg;
    assign bus.a = lane_reg[0];
    assign bus.b = lane_reg[1];
    assign bus.c = lane_reg[2];
    assign bus.d = lane_reg[3];
    assign bus.e = lane_reg[4];
    assign bus.f = lane_reg[5];
    assign bus.g = lane_reg[6];
    assign bus.h = lane_reg[7];
endmodule

// File: tb/tb_lane_deserializer8.sv
// Directed and random stimulus for lane_deserializer8, checked against a queue-based bundle model.
module tb_lane_deserializer8;
    logic clk = 1'b0;
    logic areset = 1'b1;
    int   total = 0;
    int   bad = 0;

    lane_deserializer8_if #(.WIDTH(8)) bus ();

    lane_deserializer8 #(.WIDTH(8)) dut (
        .clk   (clk),
        .areset(areset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Model: words collected for the current bundle, and whether it is being presented.
    logic [7:0] words[$];
    bit         holding = 1'b0;

    function automatic logic [63:0] model_lanes();
        logic [63:0] v = '0;
        for (int i = 0; i < 8; i++) v = {v[55:0], (i < words.size()) ? words[i] : 8'h00};
        return v;
    endfunction

    function automatic logic [63:0] dut_lanes();
        return {bus.a, bus.b, bus.c, bus.d, bus.e, bus.f, bus.g, bus.h};
    endfunction

    task automatic check(input string tag);
        logic [3:0] exp_count;
        exp_count = holding ? 4'(words.size()) : 4'd0;
        total++;
        assert (bus.in_ready === !holding) else begin
            bad++; $error("FAIL %s in_ready got=%0b want=%0b", tag, bus.in_ready, !holding);
        end
        total++;
        assert (bus.out_valid === holding) else begin
            bad++; $error("FAIL %s out_valid got=%0b want=%0b", tag, bus.out_valid, holding);
        end
        total++;
        assert (bus.out_count === exp_count) else begin
            bad++; $error("FAIL %s out_count got=%0d want=%0d", tag, bus.out_count, exp_count);
        end
        total++;
        assert (dut_lanes() === model_lanes()) else begin
            bad++; $error("FAIL %s lanes got=%h want=%h", tag, dut_lanes(), model_lanes());
        end
    endtask

    // One clock: drive inputs, advance the model on the edge, check just after it.
    task automatic step(input string tag, input logic v, input logic [7:0] d,
                        input logic l, input logic r);
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.in_last   = l;
        bus.out_ready = r;
        @(posedge clk);
        if (holding) begin
            if (r) begin
                holding = 1'b0;
                words.delete();
            end
        end else if (v) begin
            words.push_back(d);
            if (words.size() == 8 || l) holding = 1'b1;
        end
        #1;
        check(tag);
        $display("step %s: v=%0b d=%h l=%0b r=%0b -> out_valid=%0b count=%0d lanes=%h",
                 tag, v, d, l, r, bus.out_valid, bus.out_count, dut_lanes());
    endtask

    // Raise areset between edges and confirm outputs clear before the next edge.
    task automatic async_reset(input string tag);
        #2;
        areset = 1'b1;
        #1;
        holding = 1'b0;
        words.delete();
        check(tag);
        bus.in_valid = 1'b0;
        @(negedge clk);
        areset = 1'b0;
    endtask

    task automatic check_lane(input string tag, input logic [7:0] got, input logic [7:0] want);
        total++;
        assert (got === want) else begin
            bad++; $error("FAIL %s got=%h want=%h", tag, got, want);
        end
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = 8'h00;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;
        #3;
        check("reset_initial");
        @(negedge clk);
        areset = 1'b0;

        // Full bundle 0x11..0x88, then delivery clears the lanes.
        for (int i = 1; i <= 8; i++) step("full", 1'b1, 8'(i * 8'h11), 1'b0, 1'b1);
        check_lane("full_a", bus.a, 8'h11);
        check_lane("full_h", bus.h, 8'h88);
        check_lane("full_count", {4'h0, bus.out_count}, 8'd8);
        step("full_deliver", 1'b0, 8'h00, 1'b0, 1'b1);

        // Partial bundle of three.
        step("part", 1'b1, 8'h05, 1'b0, 1'b0);
        step("part", 1'b1, 8'h06, 1'b0, 1'b0);
        step("part", 1'b1, 8'h07, 1'b1, 1'b0);
        check_lane("part_c", bus.c, 8'h07);
        check_lane("part_d", bus.d, 8'h00);

        // Backpressure: five HOLD cycles with changing input data, then one delivery.
        for (int i = 0; i < 5; i++) step("bp_hold", 1'b1, 8'($urandom), 1'($urandom), 1'b0);
        check_lane("bp_b", bus.b, 8'h06);
        step("bp_deliver", 1'b1, 8'hAA, 1'b0, 1'b1);
        step("bp_after", 1'b0, 8'h00, 1'b0, 1'b1);

        // Single-word bundle, then in_last on the 8th word.
        step("single", 1'b1, 8'hFF, 1'b1, 1'b0);
        check_lane("single_count", {4'h0, bus.out_count}, 8'd1);
        step("single_deliver", 1'b0, 8'h00, 1'b0, 1'b1);
        for (int i = 1; i <= 8; i++) step("last8", 1'b1, 8'(8'h20 + i), 1'(i == 8), 1'b0);
        check_lane("last8_count", {4'h0, bus.out_count}, 8'd8);
        step("last8_deliver", 1'b0, 8'h00, 1'b0, 1'b1);

        // Reset mid-bundle and mid-HOLD, then a fresh single-word bundle.
        for (int i = 0; i < 4; i++) step("pre_reset", 1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
        async_reset("reset_mid_fill");
        step("post_reset", 1'b1, 8'h01, 1'b1, 1'b0);
        check_lane("post_reset_a", bus.a, 8'h01);
        check_lane("post_reset_b", bus.b, 8'h00);
        async_reset("reset_mid_hold");

        // Random traffic against the model.
        for (int i = 0; i < 400; i++)
            step("rand", 1'($urandom_range(0, 3) != 0), 8'($urandom),
                 1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 2) != 0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
